// File: rtl/player_cmd_encoder.sv
// player_cmd_encoder
//   Turns five debounced button levels into move/bomb command codes. Each press
//   edge raises a pending request. One pending request per cycle is granted by
//   priority (bomb > up > down > left > right) and written into a small FIFO.
//   The FIFO is drained over a valid/ready handshake.
//   Optional feature, macro PLAYER_CMD_AUTOREPEAT_EN: a held direction re-issues
//   its command after HOLD_MS and then every REPEAT_MS, timed by a 1 ms tick.
//   Without the macro, only press edges create commands.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   btn[4:0]   debounced levels, [4]=bomb [3]=up [2]=down [1]=left [0]=right (async)
//   cmd_valid  FIFO head holds a command
//   cmd_ready  engine accepts the head this cycle
//   cmd_code   1=UP 2=DOWN 3=LEFT 4=RIGHT 5=BOMB, 0 when the FIFO is empty
//   fifo_count number of stored entries
//   overflow   one-cycle pulse when a granted command is dropped
module player_cmd_encoder #(
   parameter int unsigned TICK_DIV   = 50000,
   parameter int unsigned HOLD_MS    = 300,
   parameter int unsigned REPEAT_MS  = 100,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [4:0]                    btn,
   output logic                          cmd_valid,
   input  logic                          cmd_ready,
   output logic [2:0]                    cmd_code,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   logic [4:0] sync1_q, s2_q, prev_q, rise;
   logic [4:0] pending_q, pending_d, sel_mask, rpt_set;
   logic [2:0] sel_code;
   logic       push_req, push_ok, pop;

   logic [2:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             overflow_q;

   // Input synchronizer and press-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         s2_q    <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= btn;
         s2_q    <= sync1_q;
         prev_q  <= s2_q;
      end
   end

   assign rise = s2_q & ~prev_q;

   // Fixed-priority grant of one pending request per cycle
   always_comb begin
      sel_mask = '0;
      sel_code = 3'd0;
      if (pending_q[4]) begin
         sel_mask = 5'b10000;
         sel_code = 3'd5;
      end else if (pending_q[3]) begin
         sel_mask = 5'b01000;
         sel_code = 3'd1;
      end else if (pending_q[2]) begin
         sel_mask = 5'b00100;
         sel_code = 3'd2;
      end else if (pending_q[1]) begin
         sel_mask = 5'b00010;
         sel_code = 3'd3;
      end else if (pending_q[0]) begin
         sel_mask = 5'b00001;
         sel_code = 3'd4;
      end
   end

   assign push_req  = |pending_q;
   assign pop       = cmd_valid & cmd_ready;
   assign push_ok   = push_req & ((count_q < FULL_CNT) | pop);
   // New requests are OR-ed in after the clear, so a same-cycle set survives
   assign pending_d = (pending_q & ~sel_mask) | rise | rpt_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         overflow_q <= push_req & ~push_ok;
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; entries are only visible while count is non-zero
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= sel_code;
   end

   assign cmd_valid  = (count_q != '0);
   assign cmd_code   = cmd_valid ? mem_q[rd_ptr_q] : 3'd0;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;

`ifdef PLAYER_CMD_AUTOREPEAT_EN
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   localparam int unsigned MS_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
   localparam int unsigned MS_W   = $clog2(MS_MAX + 1);
   localparam int unsigned TK_W   = $clog2(TICK_DIV + 1);
   localparam logic [TK_W-1:0] TICK_LAST   = TK_W'(TICK_DIV - 1);
   localparam logic [MS_W-1:0] HOLD_LAST   = MS_W'(HOLD_MS - 1);
   localparam logic [MS_W-1:0] REPEAT_LAST = MS_W'(REPEAT_MS - 1);

   logic [TK_W-1:0] presc_q;
   logic            tick;
   logic [MS_W-1:0] ms_q, ms_d, ms_last;
   logic [1:0]      state_q, state_d, held_q, held_d;
   logic [3:0]      dir_rise, other_rise;

   // Index of the highest-priority direction (up=3 ... right=0)
   function automatic logic [1:0] hi_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   assign tick       = (presc_q == TICK_LAST);
   assign dir_rise   = rise[3:0];
   assign other_rise = dir_rise & ~(4'b0001 << held_q);
   assign ms_last    = (state_q == ST_HOLD) ? HOLD_LAST : REPEAT_LAST;

   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      ms_d    = ms_q;
      rpt_set = '0;
      case (state_q)
         ST_IDLE: begin
            if (|dir_rise) begin
               held_d  = hi_idx(dir_rise);
               ms_d    = '0;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD, ST_REPEAT: begin
            // A new direction outranks release and timeout of the held one
            if (|other_rise) begin
               held_d  = hi_idx(other_rise);
               ms_d    = '0;
               state_d = ST_HOLD;
            end else if (!s2_q[held_q]) begin
               ms_d    = '0;
               state_d = ST_IDLE;
            end else if (tick) begin
               if (ms_q == ms_last) begin
                  rpt_set[held_q] = 1'b1;
                  ms_d            = '0;
                  state_d         = ST_REPEAT;
               end else begin
                  ms_d = ms_q + 1'b1;
               end
            end
         end
         default: begin
            ms_d    = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         ms_q    <= '0;
         state_q <= ST_IDLE;
         held_q  <= 2'd0;
      end else begin
         presc_q <= tick ? '0 : presc_q + 1'b1;
         ms_q    <= ms_d;
         state_q <= state_d;
         held_q  <= held_d;
      end
   end
`else
   assign rpt_set = '0;
`endif

endmodule
